// File: rtl/turn_signal_controller_pkg.sv
// Shared definitions for the tail-light turn signal controller: mode
// encodings, default timing parameters and small helper functions.
package tail_light_pkg;

    localparam int MODE_W             = 3;
    localparam int DEFAULT_DIV        = 4;
    localparam int DEFAULT_TAP_STEPS  = 3;
    localparam int DEFAULT_LANE_STEPS = 9;

    typedef enum logic [MODE_W-1:0] {
        MODE_IDLE   = 3'd0,
        MODE_LEFT   = 3'd1,
        MODE_RIGHT  = 3'd2,
        MODE_LANE_L = 3'd3,
        MODE_LANE_R = 3'd4,
        MODE_HAZARD = 3'd5
    } mode_e;

    // Step counter increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A turn and its lane-change extension form one continuous blink episode,
    // so moving between them keeps the step count and prescaler phase.
    function automatic logic is_lane_pair(input mode_e a, input mode_e b);
        return ((a == MODE_LEFT)   && (b == MODE_LANE_L)) ||
               ((a == MODE_LANE_L) && (b == MODE_LEFT))   ||
               ((a == MODE_RIGHT)  && (b == MODE_LANE_R)) ||
               ((a == MODE_LANE_R) && (b == MODE_RIGHT));
    endfunction

endpackage

// File: rtl/turn_signal_controller_if.sv
// Driver-control and sequencer-command bundle of the turn signal controller.
interface turn_signal_controller_if;
    import tail_light_pkg::*;

    logic              hazard_btn;
    logic              stalk_left;
    logic              stalk_right;
    logic              hazard;
    logic              left;
    logic              right;
    logic              step;
    logic [MODE_W-1:0] mode;

    // Driver-input side: supplies controls, observes commands.
    modport master (
        output hazard_btn, stalk_left, stalk_right,
        input  hazard, left, right, step, mode
    );

    // Controller side: consumes controls, drives commands.
    modport slave (
        input  hazard_btn, stalk_left, stalk_right,
        output hazard, left, right, step, mode
    );

endinterface

// File: rtl/turn_signal_controller_step_prescaler.sv
// Step-rate prescaler: registered one-cycle pulse every DIV cycles, phase
// restartable so a new mode sees its first step DIV cycles after entry.
module step_prescaler
    import tail_light_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic step
);

    localparam int               CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             step_q;

    // Count 0..DIV-1; the terminal count registers a pulse and wraps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            step_q <= 1'b0;
        end else if (restart || !enable) begin
            cnt_q  <= '0;
            step_q <= 1'b0;
        end else if (cnt_q == LAST) begin
            cnt_q  <= '0;
            step_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            step_q <= 1'b0;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/turn_signal_controller.sv
// Turn signal controller: arbitrates hazard, stalk and lane-change taps into
// one mode and drives registered command levels plus the sweep step pulse.
module turn_signal_controller
    import tail_light_pkg::*;
#(
    parameter int DIV        = DEFAULT_DIV,
    parameter int TAP_STEPS  = DEFAULT_TAP_STEPS,
    parameter int LANE_STEPS = DEFAULT_LANE_STEPS
) (
    input  logic                     clk,
    input  logic                     reset,
    turn_signal_controller_if.slave  bus
);

    localparam logic [7:0] TAP_CNT  = 8'(TAP_STEPS);
    localparam logic [7:0] LANE_CNT = 8'(LANE_STEPS);

    mode_e       mode_q, mode_d;
    logic        btn_q;
    logic        hazard_on_q, hazard_on_d;
    logic [7:0]  step_cnt_q, step_cnt_d;
    logic [7:0]  cnt_eff;
    logic        hazard_q, hazard_d;
    logic        left_q, left_d;
    logic        right_q, right_d;
    logic        restart;
    logic        step;
    logic        l_sel, r_sel;

    // Both stalk contacts closed is a fault and counts as no stalk.
    assign l_sel = bus.stalk_left  && !bus.stalk_right;
    assign r_sel = bus.stalk_right && !bus.stalk_left;

    step_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .enable  (mode_d != MODE_IDLE),
        .step    (step)
    );

    // Next mode, hazard latch, step count and command levels.
    always_comb begin
        hazard_on_d = hazard_on_q ^ (bus.hazard_btn && !btn_q);
        // A visible step pulse counts before this cycle's transition decision.
        cnt_eff     = step ? sat_inc(step_cnt_q) : step_cnt_q;
        mode_d      = mode_q;
        if (hazard_on_d) begin
            mode_d = MODE_HAZARD;
        end else begin
            case (mode_q)
                MODE_IDLE: begin
                    if (l_sel)      mode_d = MODE_LEFT;
                    else if (r_sel) mode_d = MODE_RIGHT;
                end
                MODE_LEFT: begin
                    if (!l_sel) begin
                        if (r_sel)                  mode_d = MODE_RIGHT;
                        else if (cnt_eff < TAP_CNT) mode_d = MODE_LANE_L;
                        else                        mode_d = MODE_IDLE;
                    end
                end
                MODE_RIGHT: begin
                    if (!r_sel) begin
                        if (l_sel)                  mode_d = MODE_LEFT;
                        else if (cnt_eff < TAP_CNT) mode_d = MODE_LANE_R;
                        else                        mode_d = MODE_IDLE;
                    end
                end
                MODE_LANE_L: begin
                    if (l_sel)                    mode_d = MODE_LEFT;
                    else if (r_sel)               mode_d = MODE_RIGHT;
                    else if (cnt_eff >= LANE_CNT) mode_d = MODE_IDLE;
                end
                MODE_LANE_R: begin
                    if (r_sel)                    mode_d = MODE_RIGHT;
                    else if (l_sel)               mode_d = MODE_LEFT;
                    else if (cnt_eff >= LANE_CNT) mode_d = MODE_IDLE;
                end
                MODE_HAZARD: begin
                    if (l_sel)      mode_d = MODE_LEFT;
                    else if (r_sel) mode_d = MODE_RIGHT;
                    else            mode_d = MODE_IDLE;
                end
                default: mode_d = MODE_IDLE;
            endcase
        end
        restart    = (mode_d != mode_q) && !is_lane_pair(mode_q, mode_d);
        step_cnt_d = restart ? 8'd0 : cnt_eff;
        hazard_d   = (mode_d == MODE_HAZARD);
        left_d     = (mode_d == MODE_LEFT)  || (mode_d == MODE_LANE_L);
        right_d    = (mode_d == MODE_RIGHT) || (mode_d == MODE_LANE_R);
    end

    // State and registered command outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q      <= MODE_IDLE;
            btn_q       <= 1'b0;
            hazard_on_q <= 1'b0;
            step_cnt_q  <= 8'd0;
            hazard_q    <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            btn_q       <= bus.hazard_btn;
            hazard_on_q <= hazard_on_d;
            step_cnt_q  <= step_cnt_d;
            hazard_q    <= hazard_d;
            left_q      <= left_d;
            right_q     <= right_d;
        end
    end

    assign bus.hazard = hazard_q;
    assign bus.left   = left_q;
    assign bus.right  = right_q;
    assign bus.step   = step;
    assign bus.mode   = mode_q;

endmodule
